// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event controller.
//   key_fsm_e  : per-key debounce/hold state encoding (3-bit)
//   evt_code_e : encoded event type carried on evt_type (2-bit)
//   clog2 / key_width / max3 : elaboration-time sizing helpers
package key_evt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_HELD       = 3'd2,
    ST_LONG       = 3'd3,
    ST_DB_RELEASE = 3'd4
  } key_fsm_e;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_code_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Bit width able to index/count 'value' states, never below 1.
  function automatic int unsigned key_width(input int unsigned value);
    int unsigned w;
    w = clog2(value);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Output bundle of the key event controller.
//   key_state     debounced level per key, 1 = pressed
//   press_pulse   1-cycle pulse per key on accepted press
//   release_pulse 1-cycle pulse per key on accepted release
//   long_pulse    1-cycle pulse per key when the hold reaches the long time
//   repeat_pulse  1-cycle pulse per key every repeat period while long-held
//   evt_valid     an encoded event is present this cycle
//   evt_key       index of the reporting key
//   evt_type      00 press, 01 release, 10 long, 11 repeat
// master: the controller driving the bundle; slave: the UI logic consuming it.
interface key_event_ctrl_if
  import key_evt_pkg::*;
#(
  parameter int unsigned NUM_KEYS = 4,
  parameter int unsigned KEY_W    = key_width(NUM_KEYS)
);

  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] long_pulse;
  logic [NUM_KEYS-1:0] repeat_pulse;
  logic                evt_valid;
  logic [KEY_W-1:0]    evt_key;
  logic [1:0]          evt_type;

  modport master (
    output key_state, press_pulse, release_pulse, long_pulse, repeat_pulse,
    output evt_valid, evt_key, evt_type
  );

  modport slave (
    input key_state, press_pulse, release_pulse, long_pulse, repeat_pulse,
    input evt_valid, evt_key, evt_type
  );

endinterface

// File: rtl/key_db_cell.sv
// Single-key synchroniser, debouncer and hold/repeat event generator.
//   clk, rst        system clock, asynchronous active-low reset
//   key_in          raw asynchronous key pin
//   key_state       debounced level (1 in HELD, LONG, DB_RELEASE)
//   press_pulse, release_pulse, long_pulse, repeat_pulse
//                   registered one-cycle event pulses
//   evt_next_valid, evt_next_type
//                   the event that the pulse registers capture on the next
//                   edge, so the top can register its encoded bus alongside
module key_db_cell
  import key_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_state,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       evt_next_valid,
  output logic [1:0] evt_next_type
);

  localparam int unsigned CW = key_width(max3(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);
  localparam logic          REST_LVL  = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic          sync1, sync2, raw;
  key_fsm_e      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          was_long, was_long_nxt;
  logic          press_nxt, release_nxt, long_nxt, repeat_nxt;

  // XOR with the idle level turns the pin into "pressed" polarity.
  assign raw = sync2 ^ REST_LVL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1         <= REST_LVL;
      sync2         <= REST_LVL;
      state         <= ST_IDLE;
      cnt           <= '0;
      was_long      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync1         <= key_in;
      sync2         <= sync1;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      was_long      <= was_long_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    was_long_nxt = was_long;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    repeat_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (raw) begin
          state_nxt = ST_DB_PRESS;
          cnt_nxt   = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!raw) begin
          state_nxt = ST_IDLE;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!raw) begin
          state_nxt    = ST_DB_RELEASE;
          cnt_nxt      = '0;
          was_long_nxt = 1'b0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = ST_LONG;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_LONG: begin
        if (!raw) begin
          state_nxt    = ST_DB_RELEASE;
          cnt_nxt      = '0;
          was_long_nxt = 1'b1;
        end else if (REPEAT_CYCLES != 0 && cnt == REP_LAST) begin
          cnt_nxt    = '0;
          repeat_nxt = 1'b1;
        end else begin
          // With repeat disabled the counter simply wraps; nothing observes it.
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        if (raw) begin
          // Release bounce: resume the hold phase we came from, hold timer restarts.
          state_nxt = was_long ? ST_LONG : ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt   = ST_IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    evt_next_valid = press_nxt | release_nxt | long_nxt | repeat_nxt;
    evt_next_type  = EVT_PRESS;
    if (release_nxt)     evt_next_type = EVT_RELEASE;
    else if (long_nxt)   evt_next_type = EVT_LONG;
    else if (repeat_nxt) evt_next_type = EVT_REPEAT;
  end

  assign key_state = (state == ST_HELD) || (state == ST_LONG) || (state == ST_DB_RELEASE);

endmodule

// File: rtl/key_event_ctrl.sv
// N-key debouncer and event generator for board push-buttons.
//   clk     system clock
//   rst     asynchronous, active-low reset
//   key_in  raw asynchronous key pins (NUM_KEYS)
//   evt     key_event_ctrl_if master: debounced levels, per-key pulse
//           vectors and the encoded event bus (lowest-index key wins;
//           simultaneous events on other keys appear only on the vectors)
module key_event_ctrl
  import key_evt_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 10_000_000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  key_event_ctrl_if.master    evt
);

  localparam int unsigned KW = key_width(NUM_KEYS);

  logic [NUM_KEYS-1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
  logic [NUM_KEYS-1:0] nxt_valid;
  logic [1:0]          nxt_type [NUM_KEYS];

  logic                sel_valid;
  logic [KW-1:0]       sel_key;
  logic [1:0]          sel_type;
  logic                evt_valid_q;
  logic [KW-1:0]       evt_key_q;
  logic [1:0]          evt_type_q;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_db_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_cell (
      .clk            (clk),
      .rst            (rst),
      .key_in         (key_in[g]),
      .key_state      (key_state[g]),
      .press_pulse    (press_pulse[g]),
      .release_pulse  (release_pulse[g]),
      .long_pulse     (long_pulse[g]),
      .repeat_pulse   (repeat_pulse[g]),
      .evt_next_valid (nxt_valid[g]),
      .evt_next_type  (nxt_type[g])
    );
  end

  // Encode from the cells' next-cycle events so the bus lines up with the vectors.
  always_comb begin
    sel_valid = 1'b0;
    sel_key   = '0;
    sel_type  = EVT_PRESS;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (nxt_valid[i] && !sel_valid) begin
        sel_valid = 1'b1;
        sel_key   = KW'(i);
        sel_type  = nxt_type[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      evt_type_q  <= '0;
    end else begin
      evt_valid_q <= sel_valid;
      evt_key_q   <= sel_key;
      evt_type_q  <= sel_type;
    end
  end

  assign evt.key_state     = key_state;
  assign evt.press_pulse   = press_pulse;
  assign evt.release_pulse = release_pulse;
  assign evt.long_pulse    = long_pulse;
  assign evt.repeat_pulse  = repeat_pulse;
  assign evt.evt_valid     = evt_valid_q;
  assign evt.evt_key       = evt_key_q;
  assign evt.evt_type      = evt_type_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl with DEBOUNCE=8, LONG=32, REPEAT=16, 4 active-low keys.
module tb_key_event_ctrl;

  localparam int D = 8;
  localparam int L = 32;
  localparam int R = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] key_in = '1;

  key_event_ctrl_if #(.NUM_KEYS(N)) bus ();

  key_event_ctrl #(
    .NUM_KEYS        (N),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .REPEAT_CYCLES   (R),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .evt    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: a key flips its accepted level after D+1 consecutive disagreeing
  // synchronised samples; while pressed, an unbroken run of pressed samples
  // (the first sample after a bounce does not count) times long and repeat.
  bit           m_lvl  [N];
  bit           m_long [N];
  bit           m_prev [N];
  int           m_run  [N];
  int           m_hold [N];
  logic [N-1:0] m_p1, m_p2;
  logic [N-1:0] e_state, e_press, e_rel, e_long, e_rep;
  logic         e_v;
  logic [1:0]   e_k, e_t;

  logic [3:0] press_log [2048];
  logic [3:0] rel_log   [2048];
  logic [3:0] long_log  [2048];
  logic [3:0] rep_log   [2048];
  logic [3:0] ks_log    [2048];
  logic       evv_log   [2048];
  logic [1:0] evk_log   [2048];
  logic [1:0] evt_log   [2048];

  always @(posedge clk) begin
    cyc = cyc + 1;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        m_lvl[k] = 0; m_long[k] = 0; m_prev[k] = 0; m_run[k] = 0; m_hold[k] = 0;
      end
      m_p1 = '0; m_p2 = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        bit r;
        r = m_p2[k];
        if (!m_lvl[k]) begin
          m_run[k] = r ? m_run[k] + 1 : 0;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = 1; m_run[k] = 0; m_hold[k] = 0; m_long[k] = 0; e_press[k] = 1'b1;
          end
        end else if (!r) begin
          m_run[k]  = m_run[k] + 1;
          m_hold[k] = 0;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = 0; m_run[k] = 0; e_rel[k] = 1'b1;
          end
        end else begin
          m_run[k] = 0;
          if (!m_prev[k]) begin
            m_hold[k] = 0;
          end else begin
            m_hold[k] = m_hold[k] + 1;
            if (!m_long[k] && m_hold[k] == L) begin
              m_long[k] = 1; m_hold[k] = 0; e_long[k] = 1'b1;
            end else if (m_long[k] && R != 0 && m_hold[k] == R) begin
              m_hold[k] = 0; e_rep[k] = 1'b1;
            end
          end
        end
        m_prev[k] = r;
      end
      m_p2 = m_p1;
      m_p1 = ~key_in;
    end
    for (int k = 0; k < N; k++) e_state[k] = m_lvl[k];
    e_v = 1'b0; e_k = '0; e_t = '0;
    for (int k = 0; k < N; k++) begin
      if (!e_v && (e_press[k] | e_rel[k] | e_long[k] | e_rep[k])) begin
        e_v = 1'b1;
        e_k = 2'(k);
        e_t = e_press[k] ? 2'd0 : e_rel[k] ? 2'd1 : e_long[k] ? 2'd2 : 2'd3;
      end
    end
    #1;
    chk("key_state", 32'(bus.key_state), 32'(e_state));
    chk("press_pulse", 32'(bus.press_pulse), 32'(e_press));
    chk("release_pulse", 32'(bus.release_pulse), 32'(e_rel));
    chk("long_pulse", 32'(bus.long_pulse), 32'(e_long));
    chk("repeat_pulse", 32'(bus.repeat_pulse), 32'(e_rep));
    chk("evt_valid", 32'(bus.evt_valid), 32'(e_v));
    chk("evt_key", 32'(bus.evt_key), 32'(e_k));
    chk("evt_type", 32'(bus.evt_type), 32'(e_t));
    if (cyc < 2048) begin
      press_log[cyc] = bus.press_pulse;
      rel_log[cyc]   = bus.release_pulse;
      long_log[cyc]  = bus.long_pulse;
      rep_log[cyc]   = bus.repeat_pulse;
      ks_log[cyc]    = bus.key_state;
      evv_log[cyc]   = bus.evt_valid;
      evk_log[cyc]   = bus.evt_key;
      evt_log[cyc]   = bus.evt_type;
    end
  end

  // which: 0 press, 1 release, 2 long, 3 repeat, other key_state high
  function automatic int count_hi(input int which, input int k, input int from, input int to);
    int n;
    n = 0;
    for (int c = from; c <= to; c++) begin
      logic [3:0] v;
      case (which)
        0:       v = press_log[c];
        1:       v = rel_log[c];
        2:       v = long_log[c];
        3:       v = rep_log[c];
        default: v = ks_log[c];
      endcase
      if (v[k] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t0, t1;

  initial begin
    wait_cycles(3);
    chk("reset_key_state", 32'(bus.key_state), 0);
    chk("reset_press", 32'(bus.press_pulse), 0);
    chk("reset_evt_valid", 32'(bus.evt_valid), 0);
    rst = 1'b1;
    wait_cycles(5);

    // single press then release on key 1
    t0 = cyc; key_in[1] = 1'b0;
    wait_cycles(20);
    t1 = cyc; key_in[1] = 1'b1;
    wait_cycles(20);
    chk("t1_press_early", 32'(press_log[t0+10]), 0);
    chk("t1_press_vec", 32'(press_log[t0+11]), 32'b0010);
    chk("t1_evt_valid", 32'(evv_log[t0+11]), 1);
    chk("t1_evt_key", 32'(evk_log[t0+11]), 1);
    chk("t1_evt_type", 32'(evt_log[t0+11]), 0);
    chk("t1_release_vec", 32'(rel_log[t1+11]), 32'b0010);
    chk("t1_release_type", 32'(evt_log[t1+11]), 1);
    chk("t1_press_count", 32'(count_hi(0, 1, t0, t1 + 19)), 1);

    // short glitches on key 2 are rejected
    t0 = cyc;
    key_in[2] = 1'b0; wait_cycles(5);
    key_in[2] = 1'b1; wait_cycles(2);
    key_in[2] = 1'b0; wait_cycles(5);
    key_in[2] = 1'b1; wait_cycles(20);
    chk("t2_press_count", 32'(count_hi(0, 2, t0, cyc)), 0);
    chk("t2_release_count", 32'(count_hi(1, 2, t0, cyc)), 0);
    chk("t2_state_high", 32'(count_hi(4, 2, t0, cyc)), 0);

    // long hold with auto-repeat on key 0
    t0 = cyc; key_in[0] = 1'b0;
    wait_cycles(100);
    key_in[0] = 1'b1;
    wait_cycles(20);
    chk("t3_press", 32'(press_log[t0+11]), 32'b0001);
    chk("t3_long", 32'(long_log[t0+43]), 32'b0001);
    chk("t3_long_type", 32'(evt_log[t0+43]), 2);
    chk("t3_rep1", 32'(rep_log[t0+59]), 32'b0001);
    chk("t3_rep1_type", 32'(evt_log[t0+59]), 3);
    chk("t3_rep2", 32'(rep_log[t0+75]), 32'b0001);
    chk("t3_rep3", 32'(rep_log[t0+91]), 32'b0001);
    chk("t3_rep_count", 32'(count_hi(3, 0, t0, cyc)), 3);
    chk("t3_long_count", 32'(count_hi(2, 0, t0, cyc)), 1);
    chk("t3_release", 32'(rel_log[t0+111]), 32'b0001);

    // simultaneous presses: lowest index reported
    t0 = cyc; key_in = 4'b1010;
    wait_cycles(15);
    key_in = 4'b1111;
    wait_cycles(20);
    chk("t4_press_vec", 32'(press_log[t0+11]), 32'b0101);
    chk("t4_evt_key", 32'(evk_log[t0+11]), 0);
    chk("t4_evt_type", 32'(evt_log[t0+11]), 0);

    // release bounce during HELD on key 3
    t0 = cyc; key_in[3] = 1'b0;
    wait_cycles(15);
    key_in[3] = 1'b1; wait_cycles(3);
    key_in[3] = 1'b0; wait_cycles(12);
    t1 = cyc; key_in[3] = 1'b1;
    wait_cycles(20);
    chk("t5_press_count", 32'(count_hi(0, 3, t0, cyc)), 1);
    chk("t5_no_early_release", 32'(count_hi(1, 3, t0, t1 + 10)), 0);
    chk("t5_state_held", 32'(count_hi(4, 3, t0 + 11, t1 + 10)), 30);
    chk("t5_release", 32'(rel_log[t1+11]), 32'b1000);

    // reset while key 1 is long-held
    t0 = cyc; key_in[1] = 1'b0;
    wait_cycles(50);
    rst = 1'b0;
    wait_cycles(1);
    rst = 1'b1; t1 = cyc;
    wait_cycles(60);
    key_in[1] = 1'b1;
    wait_cycles(20);
    chk("t6_long_before", 32'(long_log[t0+43]), 32'b0010);
    chk("t6_reset_state", 32'(ks_log[t0+51]), 0);
    chk("t6_reset_evt", 32'(evv_log[t0+51]), 0);
    chk("t6_press_early", 32'(press_log[t1+10]), 0);
    chk("t6_press", 32'(press_log[t1+11]), 32'b0010);
    chk("t6_no_stale_long", 32'(count_hi(2, 1, t0 + 44, t1 + 42)), 0);
    chk("t6_no_stale_rep", 32'(count_hi(3, 1, t0 + 44, t1 + 42)), 0);
    chk("t6_long_after", 32'(long_log[t1+43]), 32'b0010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
